// File: rtl/cmd_dispatch.sv
// cmd_dispatch: decodes raw processor commands into per-element command FIFOs
// and issues queued commands to each element channel with a one-cycle strobe.
// Every channel runs an IDLE/ISSUE/WAIT handshake independently of the others.
module cmd_dispatch #(
   parameter int CMD_WIDTH      = 72,
   parameter int SEL_WIDTH      = 8,
   parameter int ELEM_CMD_WIDTH = CMD_WIDTH - SEL_WIDTH,
   parameter int N_ELEM         = 2,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [CMD_WIDTH-1:0]             cmd_in,
   input  logic                             cstrobe_in,
   input  logic [N_ELEM-1:0]                elem_busy,
   input  logic                             clear_err,
   output logic [N_ELEM*ELEM_CMD_WIDTH-1:0] elem_cmd,
   output logic [N_ELEM-1:0]                elem_cstrobe,
   output logic [N_ELEM-1:0]                fifo_empty,
   output logic [N_ELEM-1:0]                overflow,
   output logic                             bad_sel
);

   // One extra pointer bit separates full from empty when the address bits match.
   localparam int                   AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]          PTR_INC   = (AW+1)'(1);
   localparam logic [SEL_WIDTH-1:0] SEL_BCAST = '1;
   localparam logic [SEL_WIDTH-1:0] SEL_LIMIT = SEL_WIDTH'(N_ELEM);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } chan_state_t;

   logic [SEL_WIDTH-1:0]      sel;
   logic [ELEM_CMD_WIDTH-1:0] payload;
   logic                      is_bcast;
   logic                      is_bad;
   logic [N_ELEM-1:0]         ovf_set;

   assign sel     = cmd_in[SEL_WIDTH-1:0];
   assign payload = cmd_in[CMD_WIDTH-1:SEL_WIDTH];

   // Classify the incoming select code: broadcast, or out-of-range and not broadcast.
   always_comb begin
      is_bcast = (sel == SEL_BCAST);
      is_bad   = cstrobe_in && !is_bcast && (sel >= SEL_LIMIT);
   end

   // Sticky error flags; a new error in the clearing cycle wins over the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= '0;
         bad_sel  <= 1'b0;
      end else begin
         overflow <= (overflow & ~{N_ELEM{clear_err}}) | ovf_set;
         bad_sel  <= (bad_sel & ~clear_err) | is_bad;
      end
   end

   for (genvar k = 0; k < N_ELEM; k++) begin : g_chan
      logic [ELEM_CMD_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [AW:0]               wr_ptr;
      logic [AW:0]               rd_ptr;
      logic                      empty;
      logic                      full;
      logic                      push_req;
      logic                      push_ok;
      logic                      pop;
      logic                      strobe;
      logic [ELEM_CMD_WIDTH-1:0] cmd_q;
      chan_state_t               state_q;
      chan_state_t               state_d;

      // FIFO status and push acceptance; a pop in the same cycle frees a full slot.
      always_comb begin
         empty    = (wr_ptr == rd_ptr);
         full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
         push_req = cstrobe_in && (is_bcast || (sel == SEL_WIDTH'(k)));
         push_ok  = push_req && (!full || pop);
      end

      assign ovf_set[k] = push_req && full && !pop;

      // FIFO pointers advance on accepted pushes and on pops.
      always_ff @(posedge clk) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_INC;
            if (pop)     rd_ptr <= rd_ptr + PTR_INC;
         end
      end

      // FIFO storage; contents need no reset because the pointers define validity.
      always_ff @(posedge clk) begin
         if (push_ok) mem[wr_ptr[AW-1:0]] <= payload;
      end

      // Issued command register, held from the pop until the next pop.
      always_ff @(posedge clk) begin
         if (reset)    cmd_q <= '0;
         else if (pop) cmd_q <= mem[rd_ptr[AW-1:0]];
      end

      // Channel state register.
      always_ff @(posedge clk) begin
         if (reset) state_q <= IDLE;
         else       state_q <= state_d;
      end

      // Next state: pop when idle with work queued, strobe once, then wait for not-busy.
      always_comb begin
         state_d = state_q;
         case (state_q)
            IDLE:    if (!empty) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (!elem_busy[k]) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // Outputs decoded from the current state.
      always_comb begin
         pop    = (state_q == IDLE) && !empty;
         strobe = (state_q == ISSUE);
      end

      assign elem_cstrobe[k]                               = strobe;
      assign fifo_empty[k]                                 = empty;
      assign elem_cmd[k*ELEM_CMD_WIDTH +: ELEM_CMD_WIDTH]  = cmd_q;
   end

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed scenarios plus a randomized run against a
// queue-based reference model of the dispatcher.
module tb_cmd_dispatch;

   localparam int CW = 72;
   localparam int SW = 8;
   localparam int EW = 64;
   localparam int N  = 2;
   localparam int D  = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [CW-1:0]   cmd_in;
   logic            cstrobe_in;
   logic [N-1:0]    elem_busy;
   logic            clear_err;
   logic [N*EW-1:0] elem_cmd;
   logic [N-1:0]    elem_cstrobe;
   logic [N-1:0]    fifo_empty;
   logic [N-1:0]    overflow;
   logic            bad_sel;

   int checks   = 0;
   int failures = 0;

   cmd_dispatch #(
      .CMD_WIDTH(CW), .SEL_WIDTH(SW), .ELEM_CMD_WIDTH(EW),
      .N_ELEM(N), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .reset(reset), .cmd_in(cmd_in), .cstrobe_in(cstrobe_in),
      .elem_busy(elem_busy), .clear_err(clear_err), .elem_cmd(elem_cmd),
      .elem_cstrobe(elem_cstrobe), .fifo_empty(fifo_empty),
      .overflow(overflow), .bad_sel(bad_sel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cstrobe_in = 1'b0;
      cmd_in     = '0;
      clear_err  = 1'b0;
   endtask

   task automatic send(input logic [7:0] s, input logic [63:0] p);
      cmd_in     = {p, s};
      cstrobe_in = 1'b1;
   endtask

   function automatic logic [63:0] ch_cmd(input int k);
      return elem_cmd[k*EW +: EW];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      elem_busy = '0;
      send(8'h00, 64'h1234);
      clear_err = 1'b1;
      tick();
      tick();
      checks++; if (elem_cstrobe !== 2'b00) begin failures++; $display("FAIL reset_strobe got=%b exp=00", elem_cstrobe); end
      checks++; if (elem_cmd !== '0) begin failures++; $display("FAIL reset_cmd got=%h exp=0", elem_cmd); end
      checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL reset_empty got=%b exp=11", fifo_empty); end
      checks++; if (overflow !== 2'b00 || bad_sel !== 1'b0) begin failures++; $display("FAIL reset_flags ovf=%b bad=%b exp=00/0", overflow, bad_sel); end
      reset = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_single();
      send(8'h01, 64'hA5);
      tick();
      idle_inputs();
      checks++; if (elem_cstrobe !== 2'b00) begin failures++; $display("FAIL single_c1_strobe got=%b exp=00", elem_cstrobe); end
      checks++; if (fifo_empty !== 2'b01) begin failures++; $display("FAIL single_c1_empty got=%b exp=01", fifo_empty); end
      tick();
      checks++; if (elem_cstrobe !== 2'b10) begin failures++; $display("FAIL single_c2_strobe got=%b exp=10", elem_cstrobe); end
      checks++; if (ch_cmd(1) !== 64'hA5) begin failures++; $display("FAIL single_cmd1 got=%h exp=a5", ch_cmd(1)); end
      checks++; if (ch_cmd(0) !== 64'h0) begin failures++; $display("FAIL single_cmd0 got=%h exp=0", ch_cmd(0)); end
      tick();
      checks++; if (elem_cstrobe !== 2'b00) begin failures++; $display("FAIL single_c3_strobe got=%b exp=00", elem_cstrobe); end
      checks++; if (ch_cmd(1) !== 64'hA5) begin failures++; $display("FAIL single_hold got=%h exp=a5", ch_cmd(1)); end
      repeat (3) tick();
   endtask

   task automatic test_broadcast();
      send(8'hFF, 64'h7);
      tick();
      idle_inputs();
      tick();
      checks++; if (elem_cstrobe !== 2'b11) begin failures++; $display("FAIL bcast_strobe got=%b exp=11", elem_cstrobe); end
      checks++; if (ch_cmd(0) !== 64'h7 || ch_cmd(1) !== 64'h7) begin failures++; $display("FAIL bcast_cmd got=%h/%h exp=7/7", ch_cmd(0), ch_cmd(1)); end
      repeat (4) tick();
   endtask

   task automatic test_overflow();
      logic [63:0] got[$];
      int last, min_gap;
      elem_busy = 2'b01;
      for (int i = 1; i <= 5; i++) begin
         send(8'h00, 64'(i));
         tick();
      end
      checks++; if (overflow !== 2'b00) begin failures++; $display("FAIL ovf_before got=%b exp=00", overflow); end
      send(8'h00, 64'd6);
      tick();
      idle_inputs();
      checks++; if (overflow !== 2'b01) begin failures++; $display("FAIL ovf_set got=%b exp=01", overflow); end
      checks++; if (ch_cmd(0) !== 64'd1) begin failures++; $display("FAIL ovf_first got=%h exp=1", ch_cmd(0)); end
      clear_err = 1'b1;
      elem_busy = 2'b00;
      tick();
      clear_err = 1'b0;
      checks++; if (overflow !== 2'b00) begin failures++; $display("FAIL ovf_clear got=%b exp=00", overflow); end
      last = -100;
      min_gap = 100;
      for (int c = 0; c < 30; c++) begin
         if (elem_cstrobe[0]) begin
            got.push_back(ch_cmd(0));
            if (c - last < min_gap) min_gap = c - last;
            last = c;
         end
         tick();
      end
      checks++; if (got.size() != 4) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=4", got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         checks++; if (got[i] !== 64'(i + 2)) begin failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, got[i], i + 2); end
      end
      checks++; if (min_gap < 3) begin failures++; $display("FAIL ovf_spacing got=%0d exp>=3", min_gap); end
   endtask

   task automatic test_bad_sel();
      int n;
      send(8'h05, 64'hDEAD);
      tick();
      idle_inputs();
      checks++; if (bad_sel !== 1'b1) begin failures++; $display("FAIL bad_set got=%b exp=1", bad_sel); end
      checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL bad_empty got=%b exp=11", fifo_empty); end
      n = 0;
      for (int c = 0; c < 4; c++) begin
         if (elem_cstrobe != 2'b00) n++;
         tick();
      end
      checks++; if (n != 0 || bad_sel !== 1'b1) begin failures++; $display("FAIL bad_quiet strobes=%0d bad=%b exp=0/1", n, bad_sel); end
      send(8'h7F, 64'h1);
      clear_err = 1'b1;
      tick();
      idle_inputs();
      checks++; if (bad_sel !== 1'b1) begin failures++; $display("FAIL bad_clear_vs_set got=%b exp=1", bad_sel); end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      checks++; if (bad_sel !== 1'b0) begin failures++; $display("FAIL bad_clear got=%b exp=0", bad_sel); end
   endtask

   task automatic test_full_pop();
      logic [63:0] got[$];
      elem_busy = 2'b10;
      for (int i = 0; i < 5; i++) begin
         send(8'h01, 64'hA0 + 64'(i));
         tick();
      end
      idle_inputs();
      elem_busy = 2'b00;
      tick();
      checks++; if (fifo_empty[1] !== 1'b0) begin failures++; $display("FAIL fullpop_queued got=%b exp=0", fifo_empty[1]); end
      send(8'h01, 64'hA5);
      tick();
      idle_inputs();
      checks++; if (overflow !== 2'b00) begin failures++; $display("FAIL fullpop_ovf got=%b exp=00", overflow); end
      for (int c = 0; c < 30; c++) begin
         if (elem_cstrobe[1]) got.push_back(ch_cmd(1));
         tick();
      end
      checks++; if (got.size() != 5) begin failures++; $display("FAIL fullpop_count got=%0d exp=5", got.size()); end
      for (int i = 0; i < got.size() && i < 5; i++) begin
         checks++; if (got[i] !== 64'hA1 + 64'(i)) begin failures++; $display("FAIL fullpop_order[%0d] got=%h exp=%h", i, got[i], 64'hA1 + 64'(i)); end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      elem_busy = 2'b01;
      for (int i = 1; i <= 4; i++) begin
         send(8'h00, 64'h10 + 64'(i));
         tick();
      end
      send(8'h09, 64'h0);
      tick();
      idle_inputs();
      checks++; if (bad_sel !== 1'b1 || fifo_empty[0] !== 1'b0) begin failures++; $display("FAIL rmid_pre bad=%b empty0=%b exp=1/0", bad_sel, fifo_empty[0]); end
      reset = 1'b1;
      send(8'h00, 64'hBEEF);
      clear_err = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      elem_busy = 2'b00;
      checks++; if (elem_cmd !== '0 || elem_cstrobe !== 2'b00) begin failures++; $display("FAIL rmid_outs cmd=%h stb=%b exp=0/00", elem_cmd, elem_cstrobe); end
      checks++; if (fifo_empty !== 2'b11) begin failures++; $display("FAIL rmid_empty got=%b exp=11", fifo_empty); end
      checks++; if (bad_sel !== 1'b0 || overflow !== 2'b00) begin failures++; $display("FAIL rmid_flags bad=%b ovf=%b exp=0/00", bad_sel, overflow); end
      n = 0;
      for (int c = 0; c < 12; c++) begin
         if (elem_cstrobe != 2'b00) n++;
         tick();
      end
      checks++; if (n != 0) begin failures++; $display("FAIL rmid_nostrobe got=%0d exp=0", n); end
   endtask

   task automatic test_random();
      logic [63:0] mq [N][$];
      logic [63:0] mcur [N];
      int          strobe_at [N];
      bit          midle [N];
      logic [N-1:0] movf, ovset, exp_stb, exp_emp;
      logic         mbad, cs, clr;
      logic [7:0]   s;
      logic [63:0]  p;
      logic [N-1:0] busy;
      int           r, cyc;
      reset = 1'b1;
      idle_inputs();
      elem_busy = '0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         mq[k].delete();
         mcur[k] = '0;
         strobe_at[k] = -10;
         midle[k] = 1'b1;
      end
      movf = '0;
      mbad = 1'b0;
      cyc = 0;
      for (int t = 0; t < 600; t++) begin
         cs  = ($urandom_range(0, 1) == 1);
         r   = int'($urandom_range(0, 9));
         if (r < 4)       s = 8'h00;
         else if (r < 7)  s = 8'h01;
         else if (r < 8)  s = 8'hFF;
         else             s = 8'($urandom_range(2, 254));
         p    = {$urandom, $urandom};
         busy = 2'($urandom_range(0, 3));
         clr  = ($urandom_range(0, 19) == 0);
         cmd_in = {p, s};
         cstrobe_in = cs;
         elem_busy = busy;
         clear_err = clr;
         ovset = '0;
         for (int k = 0; k < N; k++) begin
            bit pop, full, tgt;
            pop  = midle[k] && (mq[k].size() > 0);
            full = (mq[k].size() == D);
            tgt  = cs && (s == 8'hFF || s == 8'(k));
            if (pop) begin
               mcur[k] = mq[k].pop_front();
               strobe_at[k] = cyc + 1;
               midle[k] = 1'b0;
            end else if (!midle[k] && cyc >= strobe_at[k] + 1 && !busy[k]) begin
               midle[k] = 1'b1;
            end
            if (tgt) begin
               if (!full || pop) mq[k].push_back(p);
               else ovset[k] = 1'b1;
            end
         end
         movf = (clr ? '0 : movf) | ovset;
         mbad = (clr ? 1'b0 : mbad) | (cs && s != 8'hFF && s >= 8'(N));
         tick();
         cyc++;
         for (int k = 0; k < N; k++) begin
            exp_stb[k] = (strobe_at[k] == cyc);
            exp_emp[k] = (mq[k].size() == 0);
            checks++; if (ch_cmd(k) !== mcur[k]) begin failures++; $display("FAIL rnd_cmd%0d cyc=%0d got=%h exp=%h", k, cyc, ch_cmd(k), mcur[k]); end
         end
         checks++; if (elem_cstrobe !== exp_stb) begin failures++; $display("FAIL rnd_strobe cyc=%0d got=%b exp=%b", cyc, elem_cstrobe, exp_stb); end
         checks++; if (fifo_empty !== exp_emp) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", cyc, fifo_empty, exp_emp); end
         checks++; if (overflow !== movf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, overflow, movf); end
         checks++; if (bad_sel !== mbad) begin failures++; $display("FAIL rnd_bad cyc=%0d got=%b exp=%b", cyc, bad_sel, mbad); end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      elem_busy = '0;
      idle_inputs();
      test_reset();
      test_single();
      test_broadcast();
      test_overflow();
      test_bad_sel();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 72, raw processor command width.
REQ-002 SHALL have parameter SEL_WIDTH, default 8, element-select field width at cmd_in[SEL_WIDTH-1:0].
REQ-003 SHALL have parameter ELEM_CMD_WIDTH, default 64, fixed at CMD_WIDTH-SEL_WIDTH, element command width.
REQ-004 SHALL have parameter N_ELEM, default 2, range 1..254, number of element channels.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, power of two >=2, per-channel command FIFO depth.
REQ-006 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high.
REQ-008 SHALL have port cmd_in  input  CMD_WIDTH  raw command from proc.
REQ-009 SHALL have port cstrobe_in  input  1  cmd_in valid, one cycle per command.
REQ-010 SHALL have port elem_busy  input  N_ELEM  per-element active flag.
REQ-011 SHALL have port clear_err  input  1  clears sticky error flags.
REQ-012 SHALL have port elem_cmd  output  N_ELEM*ELEM_CMD_WIDTH  channel k at bits [k*ELEM_CMD_WIDTH +: ELEM_CMD_WIDTH].
REQ-013 SHALL have port elem_cstrobe  output  N_ELEM  per-channel command strobe.
REQ-014 SHALL have port fifo_empty  output  N_ELEM  per-channel FIFO empty.
REQ-015 SHALL have port overflow  output  N_ELEM  sticky, command dropped on full FIFO.
REQ-016 SHALL have port bad_sel  output  1  sticky, select code neither a valid channel nor broadcast.

Function
REQ-017 SHALL decode sel=cmd_in[SEL_WIDTH-1:0] and payload=cmd_in[CMD_WIDTH-1:SEL_WIDTH] when cstrobe_in=1.
REQ-018 SHALL push payload into FIFO[sel] when sel<N_ELEM.
REQ-019 SHALL treat sel=all-ones as broadcast: push payload into every channel FIFO in the same cycle.
REQ-020 SHALL drop the command and set bad_sel when N_ELEM<=sel<all-ones.
REQ-021 SHALL drop a push to a full FIFO and set overflow[k]; other broadcast targets still accept.
REQ-022 SHALL accept a push to a full FIFO when the same channel pops in the same cycle (no overflow).
REQ-023 SHALL hold sticky flags until clear_err=1; clear_err and a new error in the same cycle leave the flag set.
REQ-024 SHALL implement per-channel FSM states IDLE, ISSUE, WAIT.
REQ-025 IDLE: when FIFO non-empty, pop head into elem_cmd register, go to ISSUE.
REQ-026 ISSUE: elem_cstrobe[k]=1 for exactly this one cycle, go to WAIT.
REQ-027 WAIT: stay at least one cycle; go to IDLE in the first WAIT cycle in which elem_busy[k]=0.
REQ-028 SHALL assert elem_cstrobe[k] exactly 2 cycles after the cycle cstrobe_in is sampled, when FIFO k empty and channel IDLE.
REQ-029 SHALL space consecutive strobes on one channel by >=3 cycles; channels run independently.
REQ-030 SHALL hold elem_cmd[k] stable from ISSUE until the next pop.
REQ-031 SHALL preserve FIFO order per channel; pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, empty all FIFOs, force FSMs to IDLE and drive elem_cmd=0, elem_cstrobe=0, overflow=0, bad_sel=0 and fifo_empty=all-ones.
REQ-033 SHALL take reset with priority over cstrobe_in and clear_err in the same cycle; reset mid-WAIT discards pending commands with no further strobe.

Verification
REQ-034 Single command: cmd_in={64'hA5,8'h01}, strobe at cycle 0, busy=0 -> elem_cstrobe[1]=1 at cycle 2, elem_cmd[1]=64'hA5, channel 0 silent.
REQ-035 Broadcast: sel=8'hFF, payload 64'h7 -> both channels strobe at cycle 2 with 64'h7.
REQ-036 Overflow: elem_busy[0]=1, five pushes to ch0 (FIFO_DEPTH=4) -> first pops, next 4 fill FIFO, then a 6th push sets overflow[0]; clear_err clears it; busy release delivers the remaining 4 in order.
REQ-037 Bad select: sel=8'h05, N_ELEM=2 -> no strobe, bad_sel=1 until clear_err.
REQ-038 Full plus pop: FIFO full, push in the same cycle as the IDLE pop -> no overflow, order intact.
REQ-039 Reset mid-operation: reset in WAIT with 3 queued -> all outputs zero next cycle, no strobes afterwards.
